vec_dot_sequencer: RTL and testbench
====================================

Name: vec_dot_sequencer

Overview:
- Controller that sequences one shared radix-4 Booth multiplier instance (booth_enc_multiplier) to compute a signed dot product of two streamed vectors.
- Accepts a start command with a vector length.
- Issues one element pair per accepted handshake to the multiplier.
- Accumulates returned products and presents the final sum with a valid/ready handshake.
- Sits in the simd_vec_mac datapath between the operand stream source and the multiplier.

Parameters:
- MULT_W, 16, signed operand width; must match the multiplier's MULT_W.
- PROD_W, 2*MULT_W, signed product width returned by the multiplier.
- LEN_W, 8, width of the vector-length field; max length is 2^LEN_W-1.
- ACC_W, PROD_W+LEN_W, signed accumulator and result width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- vec_len_i  in  LEN_W  number of element pairs, unsigned; sampled with start_i.
- busy_o  out  1  high in every state except IDLE.
- op_valid_i  in  1  operand pair valid.
- op_ready_o  out  1  sequencer accepts an operand pair.
- op_a_i  in  MULT_W  signed operand a.
- op_b_i  in  MULT_W  signed operand b.
- mul_valid_o  out  1  to multiplier valid_i.
- mul_a_o  out  MULT_W  to multiplier multiplier_i.
- mul_b_o  out  MULT_W  to multiplier multiplicand_i.
- mul_prod_valid_i  in  1  from multiplier product_valid_o.
- mul_prod_i  in  PROD_W  from multiplier product_o, signed.
- acc_valid_o  out  1  dot-product result valid.
- acc_ready_i  in  1  result consumer ready.
- acc_o  out  ACC_W  signed dot product.
- err_o  out  1  sticky: unexpected product received.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy_o=0, op_ready_o=0, mul_valid_o=0, mul_a_o=0, mul_b_o=0, acc_valid_o=0, acc_o=0, err_o=0, issue and receive counters=0.
- Reset mid-operation aborts the job with no partial result. The multiplier shares rst_n, so its pipeline is also flushed.
- FSM IDLE:
  - On start_i: latch len=vec_len_i, clear acc, issue_cnt and recv_cnt, clear err_o.
  - If len!=0, go to ISSUE; otherwise go to DONE with acc=0.
- FSM ISSUE:
  - op_ready_o=1 while issue_cnt<len.
  - Handshake is op_valid_i&op_ready_o. On handshake: next cycle mul_valid_o=1 with mul_a_o/mul_b_o = the registered operands, and issue_cnt increments.
  - Without a handshake, mul_valid_o=0 next cycle; data outputs hold.
  - On the handshake where issue_cnt becomes len, go to DRAIN.
- FSM DRAIN: op_ready_o=0; when recv_cnt==len (after accumulation), go to DONE.
- FSM DONE:
  - acc_valid_o=1, acc_o holds the final sum stable.
  - acc_valid_o&acc_ready_i moves to IDLE; acc_valid_o deasserts next cycle.
  - acc_o retains its value in IDLE until the next start.
- Accumulation:
  - The multiplier has no backpressure, so products are consumed every cycle in any state.
  - In ISSUE/DRAIN with recv_cnt<len: acc += sign-extended mul_prod_i, and recv_cnt increments.
  - Arithmetic wraps modulo 2^ACC_W; no saturation.
  - Accumulation does not assume a fixed multiplier latency. Completion is determined only by recv_cnt==len.
  - A product may arrive in the same cycle as an issue; both are handled.
- Error: mul_prod_valid_i in IDLE or DONE, or with recv_cnt==len, sets err_o. The product is discarded. err_o is cleared only by the next accepted start or by reset.
- Boundary cases:
  - start_i outside IDLE is ignored; len is not relatched.
  - start_i in the cycle DONE exits is ignored; it is only accepted from IDLE.
  - len=2^LEN_W-1 must not overflow the counters; counters are LEN_W bits and compare against len.
  - Issue throughput is 1 pair/cycle with op_valid_i held high.
- Latency: the first mul_valid_o occurs 1 cycle after the first handshake. acc_valid_o rises 1 cycle after the final product is accumulated.

Test Plan:
- len=4, a={1,2,3,4}, b={5,6,7,8} back-to-back, acc_ready_i=1 -> 4 consecutive mul_valid_o pulses; acc_o=70; busy_o low 1 cycle after the result handshake.
- len=2, a={-32768,-32768}, b={-32768,32767} -> acc_o=32768; err_o=0.
- start_i with vec_len_i=0 -> acc_valid_o=1, acc_o=0 the cycle after start; no mul_valid_o pulse.
- len=3 with op_valid_i gaps of 2 cycles, and acc_ready_i low for 5 cycles after DONE, and start_i pulsed while busy -> acc_o stable while waiting; extra start ignored; correct sum; exactly 3 mul_valid_o pulses.
- len=255, all operands -32768 -> acc_o=273804165120 (255*2^30), no wrap at ACC_W=40.
- rst_n asserted mid-ISSUE, then a forced mul_prod_valid_i in IDLE -> all outputs at reset values; err_o=1 next cycle; err_o cleared by the next start.

Source files
------------

// File: rtl/vec_dot_sequencer.sv
// Sequences a shared radix-4 Booth multiplier over two streamed signed vectors and
// accumulates the returned products into a signed dot product with a valid/ready result port.
module vec_dot_sequencer #(
    parameter int MULT_W = 16,
    parameter int PROD_W = 2 * MULT_W,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = PROD_W + LEN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         vec_len_i,
    output logic                     busy_o,
    input  logic                     op_valid_i,
    output logic                     op_ready_o,
    input  logic [MULT_W-1:0]        op_a_i,
    input  logic [MULT_W-1:0]        op_b_i,
    output logic                     mul_valid_o,
    output logic [MULT_W-1:0]        mul_a_o,
    output logic [MULT_W-1:0]        mul_b_o,
    input  logic                     mul_prod_valid_i,
    input  logic [PROD_W-1:0]        mul_prod_i,
    output logic                     acc_valid_o,
    input  logic                     acc_ready_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   issue_cnt;
    logic [LEN_W-1:0]   recv_cnt;

    logic signed [ACC_W-1:0] prod_ext;
    logic                    handshake;
    logic                    accept_prod;

    assign prod_ext    = {{(ACC_W - PROD_W){mul_prod_i[PROD_W-1]}}, mul_prod_i};
    assign handshake   = op_valid_i && op_ready_o;
    assign accept_prod = mul_prod_valid_i && (state == ISSUE || state == DRAIN) && (recv_cnt != len);

    // The multiplier cannot be stalled, so products are absorbed (or flagged) in every state,
    // independently of where the issue side of the FSM currently is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len         <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            busy_o      <= 1'b0;
            op_ready_o  <= 1'b0;
            mul_valid_o <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            acc_valid_o <= 1'b0;
            acc_o       <= '0;
            err_o       <= 1'b0;
        end else begin
            mul_valid_o <= 1'b0;

            if (accept_prod) begin
                acc_o    <= acc_o + prod_ext;
                recv_cnt <= recv_cnt + LEN_W'(1);
            end else if (mul_prod_valid_i) begin
                err_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len       <= vec_len_i;
                        acc_o     <= '0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        busy_o    <= 1'b1;
                        // A stray product in the start cycle still counts as an error.
                        if (!mul_prod_valid_i) begin
                            err_o <= 1'b0;
                        end
                        if (vec_len_i != '0) begin
                            state      <= ISSUE;
                            op_ready_o <= 1'b1;
                        end else begin
                            state       <= DONE;
                            acc_valid_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        mul_valid_o <= 1'b1;
                        mul_a_o     <= op_a_i;
                        mul_b_o     <= op_b_i;
                        issue_cnt   <= issue_cnt + LEN_W'(1);
                        if (issue_cnt == len - LEN_W'(1)) begin
                            op_ready_o <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (recv_cnt == len) begin
                        state       <= DONE;
                        acc_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (acc_ready_i) begin
                        state       <= IDLE;
                        acc_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_dot_sequencer.sv
// Scoreboard bench for vec_dot_sequencer: a behavioural multiplier with random latency
// feeds products back, and expected dot products are computed with plain arithmetic.
module tb_vec_dot_sequencer;

    localparam int MULT_W = 16;
    localparam int PROD_W = 2 * MULT_W;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = PROD_W + LEN_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start_i;
    logic [LEN_W-1:0]         vec_len_i;
    logic                     busy_o;
    logic                     op_valid_i;
    logic                     op_ready_o;
    logic signed [MULT_W-1:0] op_a_i;
    logic signed [MULT_W-1:0] op_b_i;
    logic                     mul_valid_o;
    logic signed [MULT_W-1:0] mul_a_o;
    logic signed [MULT_W-1:0] mul_b_o;
    logic                     mul_prod_valid_i;
    logic [PROD_W-1:0]        mul_prod_i;
    logic                     acc_valid_o;
    logic                     acc_ready_i;
    logic signed [ACC_W-1:0]  acc_o;
    logic                     err_o;

    vec_dot_sequencer #(
        .MULT_W(MULT_W),
        .PROD_W(PROD_W),
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .vec_len_i       (vec_len_i),
        .busy_o          (busy_o),
        .op_valid_i      (op_valid_i),
        .op_ready_o      (op_ready_o),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .mul_valid_o     (mul_valid_o),
        .mul_a_o         (mul_a_o),
        .mul_b_o         (mul_b_o),
        .mul_prod_valid_i(mul_prod_valid_i),
        .mul_prod_i      (mul_prod_i),
        .acc_valid_o     (acc_valid_o),
        .acc_ready_i     (acc_ready_i),
        .acc_o           (acc_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
    } pair_t;

    typedef struct {
        longint prod;
        int     due;
    } prod_t;

    pair_t  pair_q[$];
    prod_t  prod_q[$];
    longint exp_q[$];

    int checks    = 0;
    int passed    = 0;
    int cyc       = 0;
    int pulse_cnt = 0;
    int run_len   = 0;
    int last_run  = 0;
    bit force_prod = 1'b0;

    logic signed [MULT_W-1:0] vec_a [256];
    logic signed [MULT_W-1:0] vec_b [256];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic longint wrapAcc(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    // Behavioural multiplier: checks the issued operands, then returns their product
    // after a random 0..3 cycle delay, at most one product per cycle, in order.
    always @(negedge clk) begin
        pair_t p;
        cyc++;
        if (!rst_n) begin
            prod_q.delete();
            pair_q.delete();
            mul_prod_valid_i = 1'b0;
            mul_prod_i       = '0;
            run_len          = 0;
        end else begin
            if (mul_valid_o) begin
                pulse_cnt++;
                run_len++;
                last_run = run_len;
                if (pair_q.size() == 0) begin
                    checkOutput("mul_unexpected_issue", 1, 0);
                end else begin
                    p = pair_q.pop_front();
                    checkOutput("mul_a_o", longint'(mul_a_o), p.a);
                    checkOutput("mul_b_o", longint'(mul_b_o), p.b);
                end
                prod_q.push_back('{prod: longint'(mul_a_o) * longint'(mul_b_o),
                                   due:  cyc + int'($urandom_range(0, 3))});
            end else begin
                run_len = 0;
            end

            if (force_prod) begin
                mul_prod_valid_i = 1'b1;
                mul_prod_i       = 32'h0000_1234;
            end else if (prod_q.size() > 0 && prod_q[0].due <= cyc) begin
                mul_prod_valid_i = 1'b1;
                mul_prod_i       = PROD_W'(prod_q[0].prod);
                void'(prod_q.pop_front());
            end else begin
                mul_prod_valid_i = 1'b0;
            end
        end
    end

    // Result monitor: compares acc_o against the oldest expected sum on every valid cycle
    // (so it must stay stable while stalled) and retires it on the handshake.
    always @(negedge clk) begin
        if (rst_n && acc_valid_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("acc_unexpected_valid", 1, 0);
            end else begin
                checkOutput("acc_o", longint'(acc_o), exp_q[0]);
                if (acc_ready_i) begin
                    checkOutput("err_o_at_result", longint'(err_o), 0);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy_o"},      longint'(busy_o),      0);
        checkOutput({tag, "_op_ready_o"},  longint'(op_ready_o),  0);
        checkOutput({tag, "_mul_valid_o"}, longint'(mul_valid_o), 0);
        checkOutput({tag, "_mul_a_o"},     longint'(mul_a_o),     0);
        checkOutput({tag, "_mul_b_o"},     longint'(mul_b_o),     0);
        checkOutput({tag, "_acc_valid_o"}, longint'(acc_valid_o), 0);
        checkOutput({tag, "_acc_o"},       longint'(acc_o),       0);
        checkOutput({tag, "_err_o"},       longint'(err_o),       0);
    endtask

    // Runs one job over vec_a/vec_b[0..len-1]; called at posedge+1 with the DUT idle.
    task automatic applyStimulus(input int len, input int gap_min, input int gap_max,
                                 input int hold, input bit extra, input bit b2b);
        longint sum = 0;
        int     base;
        bit     got;
        bit     extra_done = 1'b0;

        for (int i = 0; i < len; i++) begin
            sum += longint'(vec_a[i]) * longint'(vec_b[i]);
        end
        exp_q.push_back(wrapAcc(sum));
        base = pulse_cnt;

        acc_ready_i = (hold == 0);
        start_i     = 1'b1;
        vec_len_i   = LEN_W'(len);
        @(posedge clk); #1;
        start_i   = 1'b0;
        vec_len_i = LEN_W'($urandom);
        @(negedge clk);
        checkOutput("busy_after_start", longint'(busy_o), 1);
        checkOutput("err_after_start",  longint'(err_o),  0);
        if (len == 0) begin
            checkOutput("acc_valid_len0", longint'(acc_valid_o), 1);
        end
        @(posedge clk); #1;

        for (int i = 0; i < len; i++) begin
            op_a_i     = vec_a[i];
            op_b_i     = vec_b[i];
            op_valid_i = 1'b1;
            got        = 1'b0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge clk);
                if (op_ready_o) begin
                    got = 1'b1;
                    pair_q.push_back('{a: longint'(vec_a[i]), b: longint'(vec_b[i])});
                end
                @(posedge clk); #1;
            end
            op_valid_i = 1'b0;
            op_a_i     = MULT_W'($urandom);
            op_b_i     = MULT_W'($urandom);
            if (!got) begin
                checkOutput("op_handshake_timeout", 0, 1);
                break;
            end
            if (i < len - 1) begin
                repeat ($urandom_range(gap_min, gap_max)) begin
                    if (extra && !extra_done) begin
                        start_i    = 1'b1;
                        vec_len_i  = 8'd7;
                        extra_done = 1'b1;
                    end
                    @(posedge clk); #1;
                    start_i = 1'b0;
                end
            end
        end

        if (len != 0) begin
            got = 1'b0;
            for (int w = 0; w < 2000 && !got; w++) begin
                @(negedge clk);
                got = acc_valid_o;
            end
            if (!got) begin
                checkOutput("result_timeout", 0, 1);
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            acc_ready_i = 1'b1;
            if (extra) begin
                start_i   = 1'b1;
                vec_len_i = 8'd5;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
        end

        @(negedge clk);
        checkOutput("busy_after_result",      longint'(busy_o),      0);
        checkOutput("acc_valid_after_result", longint'(acc_valid_o), 0);
        checkOutput("mul_valid_pulses",       longint'(pulse_cnt - base), longint'(len));
        if (b2b) begin
            checkOutput("back_to_back_run", longint'(last_run), longint'(len));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        vec_len_i   = '0;
        op_valid_i  = 1'b0;
        op_a_i      = '0;
        op_b_i      = '0;
        acc_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] len=4 back-to-back");
        for (int i = 0; i < 4; i++) begin
            vec_a[i] = MULT_W'(i + 1);
            vec_b[i] = MULT_W'(i + 5);
        end
        applyStimulus(4, 0, 0, 0, 1'b0, 1'b1);

        $display("[TB] len=2 extreme operands");
        vec_a[0] = -16'sd32768; vec_b[0] = -16'sd32768;
        vec_a[1] = -16'sd32768; vec_b[1] = 16'sd32767;
        applyStimulus(2, 0, 0, 0, 1'b0, 1'b0);

        $display("[TB] len=0");
        applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);

        $display("[TB] len=3 with gaps, stalled result and stray starts");
        vec_a[0] = 16'sd1234;  vec_b[0] = -16'sd77;
        vec_a[1] = -16'sd500;  vec_b[1] = -16'sd321;
        vec_a[2] = 16'sd32767; vec_b[2] = 16'sd2;
        applyStimulus(3, 2, 2, 5, 1'b1, 1'b0);

        $display("[TB] len=255 all -32768");
        for (int i = 0; i < 255; i++) begin
            vec_a[i] = -16'sd32768;
            vec_b[i] = -16'sd32768;
        end
        applyStimulus(255, 0, 0, 0, 1'b0, 1'b1);

        $display("[TB] random jobs");
        for (int j = 0; j < 6; j++) begin
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                vec_a[i] = MULT_W'($urandom);
                vec_b[i] = MULT_W'($urandom);
            end
            applyStimulus(n, 0, 2, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("[TB] reset mid-issue and stray product");
        acc_ready_i = 1'b1;
        vec_len_i   = 8'd10;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            op_a_i     = MULT_W'(i + 3);
            op_b_i     = MULT_W'(i + 9);
            op_valid_i = 1'b1;
            @(negedge clk);
            if (op_ready_o) begin
                pair_q.push_back('{a: longint'(op_a_i), b: longint'(op_b_i)});
            end
            @(posedge clk); #1;
        end
        op_valid_i = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        checkResetValues("midreset");
        @(posedge clk); #1;
        rst_n      = 1'b1;
        force_prod = 1'b1;
        @(posedge clk); #1;
        force_prod = 1'b0;
        @(negedge clk);
        checkOutput("err_idle_product", longint'(err_o),  1);
        checkOutput("busy_idle_product", longint'(busy_o), 0);
        @(posedge clk); #1;

        vec_a[0] = MULT_W'($urandom);
        vec_b[0] = MULT_W'($urandom);
        applyStimulus(1, 0, 0, 0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        checkOutput("results_outstanding", longint'(exp_q.size()), 0);
        checkOutput("issues_outstanding",  longint'(pair_q.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
